// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer.
//
// Holds the per-channel FSM state encoding and the default debounce
// length (10 ms at an 80 MHz clock). Imported by debounce_ch and
// button_debouncer.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } dbc_state_e;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 800000;

endpackage : button_debouncer_pkg

// File: rtl/debounce_ch.sv
// One debounced push-button channel.
//
// Two-flop synchroniser for the asynchronous pin, polarity fold so that
// s = 1 means "pressed", then a four-state FSM with a stability counter.
// A change of s relative to the accepted level is taken only after it has
// held for DEBOUNCE_CYCLES consecutive clk edges; the accepted level and
// the single-cycle rise/fall pulses are registered.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   btn_raw    raw asynchronous pin
//   btn_level  debounced level, 1 = pressed
//   btn_rise   one-cycle pulse when a press is accepted
//   btn_fall   one-cycle pulse when a release is accepted
module debounce_ch
  import button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);

  localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  // Pin level when the button is not pressed.
  localparam logic             SYNC_IDLE = ACTIVE_LOW;

  logic             sync_p0;
  logic             sync_p1;
  logic             s;
  logic             cnt_done;
  dbc_state_e       state_q;
  dbc_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_d;
  logic             rise_d;
  logic             fall_d;

  // ---- stage p0/p1: synchroniser, back-to-back flops ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= SYNC_IDLE;
      sync_p1 <= SYNC_IDLE;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign s        = ACTIVE_LOW ? ~sync_p1 : sync_p1;
  assign cnt_done = (cnt_q == CNT_LAST);

  // ---- stage p2: FSM state, counter and registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_level <= level_d;
      btn_rise  <= rise_d;
      btn_fall  <= fall_d;
    end
  end

  // Next state. The counter restarts at 1 on entering a WAIT state because
  // the entry edge is itself the first stable sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: pulses fire on the completing edge of a WAIT state, which is
  // also the edge on which the level flips.
  always_comb begin
    rise_d  = (state_q == PRESS_WAIT)   &&  s && cnt_done;
    fall_d  = (state_q == RELEASE_WAIT) && !s && cnt_done;
    level_d = btn_level;
    if (rise_d) begin
      level_d = 1'b1;
    end else if (fall_d) begin
      level_d = 1'b0;
    end
  end

endmodule : debounce_ch

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer.
//
// Conditions the raw board button pins before they reach the gates block.
// Each channel is an independent debounce_ch; this module only replicates
// it and bundles the per-channel signals onto vector ports.
//
// Ports:
//   clk        system clock (80 MHz)
//   rst_n      asynchronous active-low reset
//   btn_raw    raw asynchronous button pins [NUM_CH]
//   btn_level  debounced levels, 1 = pressed [NUM_CH]
//   btn_rise   one-cycle accepted-press pulses [NUM_CH]
//   btn_fall   one-cycle accepted-release pulses [NUM_CH]
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] btn_raw,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_rise,
  output logic [NUM_CH-1:0] btn_fall
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_raw[i]),
      .btn_level (btn_level[i]),
      .btn_rise  (btn_rise[i]),
      .btn_fall  (btn_fall[i])
    );
  end

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
`timescale 1ns/1ps
// Bench for button_debouncer: directed scenarios followed by a randomized
// pin phase, all checked against a run-length reference model.
module tb_button_debouncer;

  localparam int N = 2;
  localparam int D = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '1;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_rise;
  logic [N-1:0] btn_fall;

  int total = 0;
  int bad   = 0;

  button_debouncer #(
    .NUM_CH          (N),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall)
  );

  always #6.25 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // Reference model: the pressed state of each pin reaches the decision
  // point two edges after it is sampled; a new level is accepted once the
  // delayed pressed state has disagreed with the current level for D edges
  // in a row.
  logic [N-1:0] m_d1   = '0;
  logic [N-1:0] m_d2   = '0;
  logic [N-1:0] m_lvl  = '0;
  logic [N-1:0] m_rise = '0;
  logic [N-1:0] m_fall = '0;
  int           m_run [N] = '{default: 0};

  always @(posedge clk or negedge rst_n) begin : model
    logic p;
    int   r;
    if (!rst_n) begin
      m_d1   <= '0;
      m_d2   <= '0;
      m_lvl  <= '0;
      m_rise <= '0;
      m_fall <= '0;
      for (int c = 0; c < N; c++) m_run[c] <= 0;
    end else begin
      for (int c = 0; c < N; c++) begin
        p = m_d2[c];
        r = (p != m_lvl[c]) ? m_run[c] + 1 : 0;
        m_rise[c] <= 1'b0;
        m_fall[c] <= 1'b0;
        if (r == D) begin
          m_lvl[c]  <= p;
          m_rise[c] <= p;
          m_fall[c] <= ~p;
          r = 0;
        end
        m_run[c] <= r;
      end
      m_d2 <= m_d1;
      m_d1 <= ~btn_raw;
    end
  end

  always @(negedge clk) begin
    check("mdl_level", 32'(btn_level), 32'(m_lvl));
    check("mdl_rise",  32'(btn_rise),  32'(m_rise));
    check("mdl_fall",  32'(btn_fall),  32'(m_fall));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives pattern bits (LSB first, 1 = pin high) on channel 0, one per
  // cycle, and counts pulses seen on that channel.
  task automatic run_pat(input logic [15:0] pat, input int len,
                         output int nrise, output int nfall);
    nrise = 0;
    nfall = 0;
    for (int i = 0; i < len; i++) begin
      btn_raw[0] = pat[i];
      @(negedge clk);
      nrise += int'(btn_rise[0]);
      nfall += int'(btn_fall[0]);
    end
  endtask

  initial begin : stim
    int nr;
    int nf;
    int hold [N];

    // Reset held: outputs stay low whatever the pins do.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      btn_raw = N'($urandom);
      check("rst_hold", {btn_level, btn_rise, btn_fall}, 0);
    end
    btn_raw = '1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("rst_idle", {btn_level, btn_rise, btn_fall}, 0);
    end

    // Clean press on channel 0: level and rise on the sixth edge.
    btn_raw[0] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      check("press_lvl",  32'(btn_level[0]), 32'(i >= 6));
      check("press_rise", 32'(btn_rise[0]),  32'(i == 6));
      check("press_ch1",  32'(btn_level[1]), 0);
    end

    // Release, then bounce rejection.
    btn_raw[0] = 1'b1;
    tick(12);
    run_pat(16'b1111_1111_1000_1000, 16, nr, nf);
    check("bounce_rise", nr, 0);
    check("bounce_fall", nf, 0);
    check("bounce_lvl",  32'(btn_level[0]), 0);
    run_pat(16'b1111_1111_1110_0000, 16, nr, nf);
    check("long_rise", nr, 1);
    check("long_fall", nf, 1);

    // Clean release: fall on the sixth edge.
    btn_raw[0] = 1'b0;
    tick(8);
    check("pre_rel_lvl", 32'(btn_level[0]), 1);
    btn_raw[0] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      check("rel_lvl",  32'(btn_level[0]), 32'(i < 6));
      check("rel_fall", 32'(btn_fall[0]),  32'(i == 6));
    end

    // Short re-press during the release wait restarts the count.
    btn_raw[0] = 1'b0;
    tick(8);
    btn_raw[0] = 1'b1;
    tick(2);
    btn_raw[0] = 1'b0;
    tick(3);
    btn_raw[0] = 1'b1;
    for (int i = 6; i <= 11; i++) begin
      tick(1);
      check("glitch_lvl",  32'(btn_level[0]), 32'(i < 11));
      check("glitch_fall", 32'(btn_fall[0]),  32'(i == 11));
    end

    // Both channels pressed together.
    tick(10);
    btn_raw = '0;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      check("sim_lvl",  32'(btn_level), (i >= 6) ? 3 : 0);
      check("sim_rise", 32'(btn_rise),  (i == 6) ? 3 : 0);
    end

    // Reset during PRESS_WAIT with the pin kept pressed.
    btn_raw = '1;
    tick(12);
    btn_raw[0] = 1'b0;
    tick(4);
    #2 rst_n = 1'b0;
    #1 check("rst_wait", {btn_level, btn_rise, btn_fall}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      check("rq_rise", 32'(btn_rise[0]),  32'(i == 6));
      check("rq_lvl",  32'(btn_level[0]), 32'(i >= 6));
    end

    // Reset while PRESSED drops the level with no clock edge.
    btn_raw = '0;
    tick(8);
    check("pre_rst_lvl", 32'(btn_level), 3);
    #2 rst_n = 1'b0;
    #1 check("rst_async", {btn_level, btn_rise, btn_fall}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      check("rp_rise", 32'(btn_rise), (i == 6) ? 3 : 0);
    end

    // Randomized pins with occasional asynchronous resets.
    for (int c = 0; c < N; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          btn_raw[c] = 1'($urandom_range(0, 1));
          hold[c]    = $urandom_range(1, 10);
        end else begin
          hold[c]--;
        end
      end
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #1 check("rnd_rst", {btn_level, btn_rise, btn_fall}, 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_button_debouncer
